tug_of_war_ctrl: RTL
====================

Name: tug_of_war_ctrl

Overview:
Parametrised successor to the fixed 15-position tug-of-war controller, sitting between the two player ADC sample streams and the LED screen driver.
- Multi mode: moves a rope position one step per game tick toward the player with the larger sample, with a deadband.
- Single mode: quantises player 1's level onto the same position scale.
- Adds start/idle/win sequencing, a configurable tick rate and saturating per-player win counters.

Parameters:
DATA_W, 12, width of player sample inputs
NUM_POS, 15, rope positions (odd, >=3); CENTER=(NUM_POS-1)/2
TICK_DIV, 1000000, clk cycles per game tick (>=2)
DEADBAND, 16, |p1-p2| must exceed this to step
SCORE_W, 4, width of each win counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
p1data  in  DATA_W  player 1 sample (unsigned)
p2data  in  DATA_W  player 2 sample (unsigned)
mode  in  1  0=single (meter), 1=multi (tug-of-war); latched at start
start  in  1  level/pulse; begins a game or acknowledges a win
pos  out  $clog2(NUM_POS)  rope/meter position for screen driver
tick  out  1  one-cycle strobe on every game tick in PLAY
game_over  out  1  high in P1_WIN/P2_WIN
winner  out  2  00 none, 01 P1, 10 P2
p1_score  out  SCORE_W  P1 wins, saturating
p2_score  out  SCORE_W  P2 wins, saturating

Behaviour:
- Reset (reset=0, async): state=IDLE, pos=CENTER, tick=0, game_over=0, winner=00, scores=0, sample regs=0, tick counter=0, mode_q=0. Reset dominates all other inputs.
- p1data/p2data are registered every clk into p1s/p2s. All decisions use p1s/p2s, giving 1 cycle of input latency.
- IDLE:
  - pos held at CENTER.
  - start=1 -> PLAY next edge; mode_q<=mode; tick counter cleared.
- PLAY:
  - Tick counter runs 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle the counter equals TICK_DIV-1. Pos/state update on that cycle's closing edge.
  - The first update is visible TICK_DIV cycles after entering PLAY. start is ignored.
- Multi mode (mode_q=1), on tick:
  - diff = p1s - p2s, computed signed at DATA_W+1 bits.
  - diff > DEADBAND: pos+1.
  - diff < -DEADBAND: pos-1.
  - otherwise (including equality): hold.
  - A step that makes pos=NUM_POS-1: same edge -> P1_WIN, p1_score+1 (saturating at 2^SCORE_W-1).
  - A step that makes pos=0: same edge -> P2_WIN, p2_score+1 (saturating).
- Single mode (mode_q=0), on tick:
  - pos <= (p1s*NUM_POS)>>DATA_W, with the product held in DATA_W+$clog2(NUM_POS)+1 bits. The result is always in 0..NUM_POS-1.
  - No win detection; stays in PLAY. start=1 in the cycle tick=1 -> IDLE (mode exit).
- P1_WIN/P2_WIN:
  - pos frozen at its extreme; game_over=1; winner=01/10; tick=0; counter held at 0.
  - start=1 -> IDLE next edge, pos<=CENTER.
- Any undefined state encoding -> IDLE.
- mode changes outside IDLE are ignored.

Decomposition:
- Package tug_pkg:
  - state_t enum (IDLE, PLAY, P1_WIN, P2_WIN)
  - winner encodings WIN_NONE/WIN_P1/WIN_P2
  - POS_W/CNT_W helper functions built on $clog2
- Sub-module tick_gen: parametrised TICK_DIV divider with enable and synchronous clear. Outputs a one-cycle strobe; same async active-low reset.

Test Plan (NUM_POS=15, TICK_DIV=4, DEADBAND=16, SCORE_W=2):
1. Reset low mid-PLAY at pos=10 -> pos=7, winner=00, scores=0 immediately (async). Release and hold start=0 -> stays IDLE, pos=7.
2. Multi; p1=0x800, p2=0x400; pulse start -> tick every 4th cycle; pos 7->8->...->14 over 7 ticks. On reaching 14: game_over=1, winner=01, p1_score=1 on the same edge. Further ticks absent.
3. Multi; p1=0x410, p2=0x400 (diff=16) -> pos stays 7 across 10 ticks. Set p1=0x411 -> pos=8 on next tick. Set p1=0x3EF (diff=-17) -> pos back to 7.
4. Multi; p2 dominant for 7 ticks -> pos=0, winner=10, p2_score=1. start -> IDLE, pos=7. Repeat P2 win 4 times total -> p2_score saturates at 3.
5. Single; start with mode=0 -> p1=0x000 gives pos 0; p1=0x800 gives pos 7; p1=0xFFF gives pos 14. No game_over at 14. Toggling mode during PLAY has no effect. start during tick -> IDLE.
6. start held high continuously through a P1 win -> after the win, IDLE on the next edge, then PLAY on the following edge. Scores unchanged by IDLE/PLAY transitions.

Source files
------------

// File: rtl/tug_pkg.sv
// Shared types and width helpers for the tug-of-war controller.
// Pure declarations: no latency, no flow control.
package tug_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PLAY   = 2'd1,
      P1_WIN = 2'd2,
      P2_WIN = 2'd3
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   function automatic int pos_w(input int num_pos);
      return (num_pos > 1) ? $clog2(num_pos) : 1;
   endfunction

   function automatic int cnt_w(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Game tick divider: strobe for one cycle every TICK_DIV enabled cycles.
// Strobe is combinational off the counter; no backpressure, clr wins over en.
module tick_gen
   import tug_pkg::*;
#(
   parameter int TICK_DIV = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic strobe
);

   localparam int CW = cnt_w(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign strobe = en && !clr && (cnt == LAST);

endmodule

// File: rtl/tug_of_war_ctrl.sv
// Tug-of-war / level-meter controller between two sample streams and the LED screen.
// Samples take one cycle; pos moves on the game tick; no backpressure (screen is a pure sink).
module tug_of_war_ctrl
   import tug_pkg::*;
#(
   parameter int DATA_W   = 12,
   parameter int NUM_POS  = 15,
   parameter int TICK_DIV = 1000000,
   parameter int DEADBAND = 16,
   parameter int SCORE_W  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_W-1:0]          p1data,
   input  logic [DATA_W-1:0]          p2data,
   input  logic                       mode,
   input  logic                       start,
   output logic [pos_w(NUM_POS)-1:0]  pos,
   output logic                       tick,
   output logic                       game_over,
   output logic [1:0]                 winner,
   output logic [SCORE_W-1:0]         p1_score,
   output logic [SCORE_W-1:0]         p2_score
);

   localparam int PW     = pos_w(NUM_POS);
   localparam int PROD_W = DATA_W + $clog2(NUM_POS) + 1;
   localparam logic [PW-1:0] CENTER  = PW'((NUM_POS - 1) / 2);
   localparam logic [PW-1:0] POS_MAX = PW'(NUM_POS - 1);
   localparam logic signed [DATA_W:0] DB_S = (DATA_W + 1)'(DEADBAND);

   state_t state, state_nxt;
   logic [DATA_W-1:0] p1s, p2s;
   logic mode_q;
   logic tick_s;
   logic signed [DATA_W:0] diff;
   logic step_up, step_dn, p1_hit, p2_hit;
   logic [PW-1:0] pos_step, quant, pos_nxt;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk    (clk),
      .rst_n  (reset),
      .en     (state == PLAY),
      .clr    (state != PLAY),
      .strobe (tick_s)
   );

   // Zero-extend before subtracting so the sign bit is the true comparison result.
   assign diff     = $signed({1'b0, p1s}) - $signed({1'b0, p2s});
   assign step_up  = diff > DB_S;
   assign step_dn  = diff < -DB_S;
   assign pos_step = step_up ? pos + 1'b1 : (step_dn ? pos - 1'b1 : pos);
   assign p1_hit   = mode_q && step_up && (pos_step == POS_MAX);
   assign p2_hit   = mode_q && step_dn && (pos_step == '0);
   assign quant    = PW'((PROD_W'(p1s) * PROD_W'(NUM_POS)) >> DATA_W);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (start) state_nxt = PLAY;
         PLAY: begin
            if (tick_s) begin
               if (p1_hit)                 state_nxt = P1_WIN;
               else if (p2_hit)            state_nxt = P2_WIN;
               else if (!mode_q && start)  state_nxt = IDLE;
            end
         end
         P1_WIN, P2_WIN: if (start) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tick      = 1'b0;
      game_over = 1'b0;
      winner    = WIN_NONE;
      case (state)
         PLAY:   tick = tick_s;
         P1_WIN: begin game_over = 1'b1; winner = WIN_P1; end
         P2_WIN: begin game_over = 1'b1; winner = WIN_P2; end
         default: ;
      endcase
   end

   always_comb begin
      pos_nxt = pos;
      case (state)
         IDLE: pos_nxt = CENTER;
         PLAY: begin
            if (tick_s) begin
               if (mode_q)     pos_nxt = pos_step;
               else if (start) pos_nxt = CENTER;
               else            pos_nxt = quant;
            end
         end
         P1_WIN, P2_WIN: if (start) pos_nxt = CENTER;
         default: pos_nxt = CENTER;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pos      <= CENTER;
         p1s      <= '0;
         p2s      <= '0;
         mode_q   <= 1'b0;
         p1_score <= '0;
         p2_score <= '0;
      end else begin
         pos <= pos_nxt;
         p1s <= p1data;
         p2s <= p2data;
         if (state == IDLE && start) mode_q <= mode;
         if (state == PLAY && tick_s && p1_hit && p1_score != '1) p1_score <= p1_score + 1'b1;
         if (state == PLAY && tick_s && p2_hit && p2_score != '1) p2_score <= p2_score + 1'b1;
      end
   end

endmodule
